// File: rtl/uart_rx_seq_check.sv
// uart_rx_seq_check
// Receives a UART 8N1 line and checks the incoming characters against the
// ASCII sequence '0'..'z' (8'h30..8'h7A). The sequence steps up by 1 and wraps
// from 'z' back to '0'. Characters arrive in bursts of BURST_LEN. The block
// reports framing errors and sequence mismatches, and marks each completed
// burst.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx         asynchronous UART line, idle high
//   clear_err  one-cycle pulse, clears seq_err and err_count
//   rx_data    last correctly framed byte
//   rx_done    one-cycle pulse when rx_data updates
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   seq_err    sticky flag, set on a sequence mismatch
//   err_count  mismatch count, saturates at 255
//   burst_done one-cycle pulse, coincident with the rx_done that completes a burst
//   char_idx   position within the current burst, 0..BURST_LEN-1
module uart_rx_seq_check #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD      = 9600,
   parameter int BURST_LEN = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       clear_err,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       frame_err,
   output logic       seq_err,
   output logic [7:0] err_count,
   output logic       burst_done,
   output logic [3:0] char_idx
);

   localparam int               DIV        = CLK_FREQ / (BAUD * 16);
   localparam int               DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
   localparam logic [3:0]       IDX_LAST   = 4'(BURST_LEN - 1);
   localparam logic [7:0]       CHAR_FIRST = 8'h30;
   localparam logic [7:0]       CHAR_LAST  = 8'h7A;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   logic             rx_meta_r;
   logic             rxs_r;
   logic [DIV_W-1:0] div_cnt_r;
   logic             tick_s;
   state_t           state_r;
   logic [3:0]       tcnt_r;
   logic [2:0]       bit_r;
   logic [7:0]       shift_r;
   logic [7:0]       expected_r;

   // Next character the stream should carry. This resyncs to the byte actually
   // received, so one dropped character costs a single error, not a cascade.
   function automatic logic [7:0] next_expected(input logic [7:0] b);
      if (b == CHAR_LAST) begin
         next_expected = CHAR_FIRST;
      end else begin
         next_expected = b + 8'd1;
      end
   endfunction

   // Saturating increment for the error counter.
   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      if (c == 8'hFF) begin
         sat_inc = 8'hFF;
      end else begin
         sat_inc = c + 8'd1;
      end
   endfunction

   // Two-flop synchronizer on the asynchronous rx line.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rxs_r     <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rxs_r     <= rx_meta_r;
      end
   end

   // 16x oversampling tick.
   always_comb begin
      tick_s = (div_cnt_r == DIV_LAST);
   end

   // Free-running divider. Only rst restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_r <= '0;
      end else if (tick_s) begin
         div_cnt_r <= '0;
      end else begin
         div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
   end

   // Receive FSM: framing, data capture, output pulses and burst position.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         tcnt_r     <= 4'd0;
         bit_r      <= 3'd0;
         shift_r    <= 8'h00;
         rx_data    <= 8'h00;
         rx_done    <= 1'b0;
         frame_err  <= 1'b0;
         burst_done <= 1'b0;
         char_idx   <= 4'd0;
      end else begin
         rx_done    <= 1'b0;
         frame_err  <= 1'b0;
         burst_done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!rxs_r) begin
                  state_r <= START;
                  tcnt_r  <= 4'd0;
               end
            end
            START: begin
               // Re-check the line at mid start bit. A line that is already
               // high again was only a glitch.
               if (tick_s) begin
                  if (tcnt_r == 4'd7) begin
                     tcnt_r <= 4'd0;
                     bit_r  <= 3'd0;
                     if (!rxs_r) begin
                        state_r <= DATA;
                     end else begin
                        state_r <= IDLE;
                     end
                  end else begin
                     tcnt_r <= tcnt_r + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick_s) begin
                  if (tcnt_r == 4'd15) begin
                     tcnt_r  <= 4'd0;
                     shift_r <= {rxs_r, shift_r[7:1]};
                     if (bit_r == 3'd7) begin
                        state_r <= STOP;
                     end else begin
                        bit_r <= bit_r + 3'd1;
                     end
                  end else begin
                     tcnt_r <= tcnt_r + 4'd1;
                  end
               end
            end
            STOP: begin
               if (tick_s) begin
                  if (tcnt_r == 4'd15) begin
                     tcnt_r <= 4'd0;
                     if (rxs_r) begin
                        rx_data <= shift_r;
                        rx_done <= 1'b1;
                        state_r <= IDLE;
                        if (char_idx == IDX_LAST) begin
                           burst_done <= 1'b1;
                           char_idx   <= 4'd0;
                        end else begin
                           char_idx <= char_idx + 4'd1;
                        end
                     end else begin
                        frame_err <= 1'b1;
                        state_r   <= WAIT_HIGH;
                     end
                  end else begin
                     tcnt_r <= tcnt_r + 4'd1;
                  end
               end
            end
            WAIT_HIGH: begin
               if (rxs_r) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Sequence checker. It runs in the rx_done cycle on the freshly updated
   // rx_data, so a clear_err in that same cycle loses to a mismatch.
   always_ff @(posedge clk) begin
      if (rst) begin
         seq_err    <= 1'b0;
         err_count  <= 8'h00;
         expected_r <= CHAR_FIRST;
      end else begin
         if (rx_done) begin
            expected_r <= next_expected(rx_data);
         end else begin
            expected_r <= expected_r;
         end
         if (rx_done && (rx_data != expected_r)) begin
            seq_err <= 1'b1;
            if (clear_err) begin
               err_count <= 8'd1;
            end else begin
               err_count <= sat_inc(err_count);
            end
         end else if (clear_err) begin
            seq_err   <= 1'b0;
            err_count <= 8'h00;
         end else begin
            seq_err   <= seq_err;
            err_count <= err_count;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_seq_check.sv
// Bench for uart_rx_seq_check. It runs with a divider of 1 (tick every clock),
// so one bit lasts 16 clocks. Every valid frame pushes its expected
// {burst_done, byte} into a scoreboard. A negedge monitor pops the scoreboard
// on each rx_done.
module tb_uart_rx_seq_check;

   localparam int BIT_CLKS  = 16;
   localparam int IDLE_CLKS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic       clear_err = 1'b0;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       seq_err;
   logic [7:0] err_count;
   logic       burst_done;
   logic [3:0] char_idx;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int ferr_cnt = 0;
   int burst_cnt = 0;
   logic [8:0] sb_q[$];
   logic [3:0] model_idx = 4'd0;

   uart_rx_seq_check #(
      .CLK_FREQ (16),
      .BAUD     (1),
      .BURST_LEN(16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .clear_err (clear_err),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .seq_err   (seq_err),
      .err_count (err_count),
      .burst_done(burst_done),
      .char_idx  (char_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_status(input string tag, input logic exp_seq, input logic [7:0] exp_cnt);
      check({tag, "_seq_err"}, 32'(seq_err), 32'(exp_seq));
      check({tag, "_err_count"}, 32'(err_count), 32'(exp_cnt));
      check({tag, "_char_idx"}, 32'(char_idx), 32'(model_idx));
   endtask

   // Scoreboard monitor: every rx_done or burst_done must match the oldest expected frame.
   always @(negedge clk) begin
      if (rx_done) done_cnt++;
      if (frame_err) ferr_cnt++;
      if (burst_done) burst_cnt++;
      if (rx_done || burst_done) begin
         check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            logic [8:0] e;
            e = sb_q.pop_front();
            check("sb_frame", {22'd0, rx_done, burst_done, rx_data}, {22'd0, 1'b1, e});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic good);
      if (good) begin
         sb_q.push_back({(model_idx == 4'd15), b});
         model_idx = (model_idx == 4'd15) ? 4'd0 : model_idx + 4'd1;
      end
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx = good;
      repeat (BIT_CLKS) @(negedge clk);
      rx = 1'b1;
      repeat (IDLE_CLKS) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_idx = 4'd0;
      @(negedge clk);
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rx_data"}, 32'(rx_data), 32'h00);
      check({tag, "_rx_done"}, 32'(rx_done), 32'd0);
      check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      check({tag, "_burst_done"}, 32'(burst_done), 32'd0);
      check_status(tag, 1'b0, 8'd0);
   endtask

   initial begin
      int d0, b0, f0;
      logic found;

      // 1: reset values and a full burst '0'..'?'
      do_reset();
      check_reset_vals("reset");
      d0 = done_cnt;
      b0 = burst_cnt;
      for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i), 1'b1);
      check("burst1_dones", done_cnt - d0, 16);
      check("burst1_bursts", burst_cnt - b0, 1);
      check("burst1_rx_data", 32'(rx_data), 32'h3F);
      check_status("burst1", 1'b0, 8'd0);

      // 2: wrap z -> 0. The first 'x' resyncs and is cleared.
      b0 = burst_cnt;
      send_byte(8'h78, 1'b1);
      check_status("preload", 1'b1, 8'd1);
      pulse_clear();
      send_byte(8'h79, 1'b1);
      send_byte(8'h7A, 1'b1);
      send_byte(8'h30, 1'b1);
      for (int i = 0; i < 12; i++) send_byte(8'h31 + 8'(i), 1'b1);
      check_status("wrap", 1'b0, 8'd0);
      check("wrap_bursts", burst_cnt - b0, 1);
      send_byte(8'h78, 1'b1);
      pulse_clear();
      send_byte(8'h79, 1'b1);
      send_byte(8'h7A, 1'b1);
      check_status("pre_7b", 1'b0, 8'd0);
      send_byte(8'h7B, 1'b1);
      check_status("after_z_7b", 1'b1, 8'd1);

      // 3: dropped character
      do_reset();
      send_byte(8'h30, 1'b1);
      send_byte(8'h31, 1'b1);
      check_status("drop_pre", 1'b0, 8'd0);
      send_byte(8'h33, 1'b1);
      check_status("drop_hit", 1'b1, 8'd1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h35, 1'b1);
      check_status("drop_resync", 1'b1, 8'd1);

      // 4: framing error, then a valid frame (expected is '6', so 'B' mismatches)
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_byte(8'h41, 1'b0);
      check("ferr_pulses", ferr_cnt - f0, 1);
      check("ferr_no_done", done_cnt - d0, 0);
      check("ferr_rx_data", 32'(rx_data), 32'h35);
      check_status("ferr", 1'b1, 8'd1);
      send_byte(8'h42, 1'b1);
      check("ferr_next_data", 32'(rx_data), 32'h42);
      check_status("ferr_next", 1'b1, 8'd2);

      // 5: glitch, then reset in mid-frame
      d0 = done_cnt;
      f0 = ferr_cnt;
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_no_done", done_cnt - d0, 0);
      check("glitch_no_ferr", ferr_cnt - f0, 0);
      send_byte(8'h43, 1'b1);
      check("glitch_next_data", 32'(rx_data), 32'h43);
      check_status("glitch_next", 1'b1, 8'd2);
      d0 = done_cnt;
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      rx = 1'b0;
      repeat (2 * BIT_CLKS) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLKS / 2) @(negedge clk);
      do_reset();
      repeat (200) @(negedge clk);
      check_reset_vals("midreset");
      check("midreset_no_done", done_cnt - d0, 0);
      send_byte(8'h30, 1'b1);
      check("midreset_next_data", 32'(rx_data), 32'h30);
      check_status("midreset_next", 1'b0, 8'd0);

      // 6: clear_err, coincident clear and mismatch, saturation
      for (int i = 0; i < 3; i++) send_byte(8'h7B, 1'b1);
      check_status("three_errs", 1'b1, 8'd3);
      pulse_clear();
      check_status("cleared", 1'b0, 8'd0);
      fork
         send_byte(8'h7B, 1'b1);
      join_none
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         if (rx_done) found = 1'b1;
      end
      check("coinc_done_seen", 32'(found), 32'd1);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      wait fork;
      check_status("coinc", 1'b1, 8'd1);
      for (int i = 0; i < 253; i++) send_byte(8'h7B, 1'b1);
      check_status("sat_254", 1'b1, 8'd254);
      for (int i = 0; i < 7; i++) send_byte(8'h7B, 1'b1);
      check_status("sat_255", 1'b1, 8'd255);

      repeat (20) @(negedge clk);
      check("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
